// File: rtl/cereal_tx.sv
// Purpose : UART-style serialiser: start bit, DATA_WIDTH data bits (LSB or MSB first),
// Latency : optional parity, 1-2 stop bits; cereal goes low the cycle after accept.
// Backpr. : ready is high in IDLE and in the final stop-bit cycle; start while busy is dropped.
//
// Ports:
//   sysclk  - system clock, all state on the rising edge
//   reset_n - asynchronous active-low reset
//   data    - payload, sampled only on the accept edge (start & ready)
//   start   - request to send
//   ready   - can accept a word this cycle
//   busy    - frame in progress
//   done    - one-cycle pulse in the last cycle of the final stop bit
//   cereal  - registered serial line, idles high
module cereal_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 50,
    parameter int MSB_FIRST    = 0,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  sysclk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cereal
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);
    localparam int SB = (STOP_BITS == 2) ? 2 : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(SB - 1);

    // Out-of-range framing parameters fall back to no parity / one stop bit.
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("cereal_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("cereal_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  cereal_d, ready_d, busy_d, done_d;
    logic                  accept;
    logic                  bit_end;

    // ready_q is already "IDLE or final stop cycle", so it doubles as the accept gate.
    assign accept  = start && ready;
    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;

        if (accept) begin
            state_d   = S_START;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = data;
            par_d     = (PARITY == 2) ? ~^data : ^data;
        end else if (state_q != S_IDLE) begin
            if (!bit_end) begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end else begin
                clk_cnt_d = '0;
                case (state_q)
                    S_START: begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                    S_DATA: begin
                        // Shift so the next bit to send always sits at the output end.
                        if (MSB_FIRST != 0) shreg_d = shreg_q << 1;
                        else                shreg_d = shreg_q >> 1;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d   = PAR_EN ? S_PARITY : S_STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        state_d   = S_STOP;
                        bit_cnt_d = '0;
                    end
                    S_STOP: begin
                        if (bit_cnt_q == STOP_LAST) begin
                            state_d   = S_IDLE;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                    end
                endcase
            end
        end

        // Outputs are computed from next state so they are registered yet cycle-aligned.
        case (state_d)
            S_START:  cereal_d = 1'b0;
            S_DATA:   cereal_d = (MSB_FIRST != 0) ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
            S_PARITY: cereal_d = par_d;
            default:  cereal_d = 1'b1;
        endcase
        done_d  = (state_d == S_STOP) && (bit_cnt_d == STOP_LAST) && (clk_cnt_d == CLK_LAST);
        ready_d = (state_d == S_IDLE) || done_d;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            cereal    <= 1'b1;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            cereal    <= cereal_d;
            ready     <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_cereal_tx.sv
// Purpose : self-checking bench for cereal_tx across four parameter sets.
// Latency : frames compared cycle by cycle against hand-written bit patterns.
// Backpr. : covers back-to-back start, ignored start while busy, and mid-frame reset.
module tb_cereal_tx;

    logic        sysclk = 1'b0;
    logic        reset_n;
    logic [3:0]  start_v;
    logic [7:0]  d0, d1;
    logic [11:0] d2;
    logic [3:0]  d3;
    logic [3:0]  cer_v, rdy_v, busy_v, done_v;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 sysclk = ~sysclk;

    // u0: defaults. u1: MSB first, even parity, 2 stop, 4 clk/bit.
    // u2: 12-bit, odd parity, 3 clk/bit. u3: 4-bit, 1 clk/bit.
    cereal_tx u0 (.sysclk(sysclk), .reset_n(reset_n), .data(d0), .start(start_v[0]),
                  .ready(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0]), .cereal(cer_v[0]));
    cereal_tx #(.CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY(1), .STOP_BITS(2)) u1 (
                  .sysclk(sysclk), .reset_n(reset_n), .data(d1), .start(start_v[1]),
                  .ready(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1]), .cereal(cer_v[1]));
    cereal_tx #(.DATA_WIDTH(12), .CLKS_PER_BIT(3), .PARITY(2)) u2 (
                  .sysclk(sysclk), .reset_n(reset_n), .data(d2), .start(start_v[2]),
                  .ready(rdy_v[2]), .busy(busy_v[2]), .done(done_v[2]), .cereal(cer_v[2]));
    cereal_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) u3 (
                  .sysclk(sysclk), .reset_n(reset_n), .data(d3), .start(start_v[3]),
                  .ready(rdy_v[3]), .busy(busy_v[3]), .done(done_v[3]), .cereal(cer_v[3]));

    // exp holds the line bits in transmission order, first bit leftmost, nb digits wide.
    typedef struct {
        int          inst;
        logic [31:0] dat;
        logic [15:0] exp;
        int          nb;
        int          cpb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    task automatic set_data(input int inst, input logic [31:0] v);
        case (inst)
            0:       d0 = v[7:0];
            1:       d1 = v[7:0];
            2:       d2 = v[11:0];
            default: d3 = v[3:0];
        endcase
    endtask

    // Entered at #1 after the accept edge; returns at #1 after the final stop-bit cycle edge.
    task automatic check_frame(input int inst, input logic [15:0] exp, input int nb,
                               input int cpb, input string nm);
        int len;
        int k;
        int busy_bad, done_bad, rdy_bad, bad;
        len = nb * cpb;
        busy_bad = 0; done_bad = 0; rdy_bad = 0;
        for (int b = 0; b < nb; b++) begin
            bad = 0;
            for (int c = 0; c < cpb; c++) begin
                k = b * cpb + c;
                if (k != 0) begin
                    @(posedge sysclk);
                    #1;
                end
                if (cer_v[inst] !== exp[nb-1-b]) bad++;
                if (busy_v[inst] !== 1'b1) busy_bad++;
                if (done_v[inst] !== (k == len - 1)) done_bad++;
                if (rdy_v[inst] !== (k == len - 1)) rdy_bad++;
            end
            chk($sformatf("%s bit%0d bad cycles", nm, b), bad, 0);
        end
        chk($sformatf("%s busy bad cycles", nm), busy_bad, 0);
        chk($sformatf("%s done bad cycles", nm), done_bad, 0);
        chk($sformatf("%s ready bad cycles", nm), rdy_bad, 0);
    endtask

    task automatic check_idle(input int inst, input int n, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
            if ({cer_v[inst], rdy_v[inst], busy_v[inst], done_v[inst]} !== 4'b1100) bad++;
        end
        chk($sformatf("%s idle bad cycles", nm), bad, 0);
    endtask

    task automatic run_vec(input int v);
        @(posedge sysclk);
        #1;
        set_data(vecs[v].inst, vecs[v].dat);
        start_v[vecs[v].inst] = 1'b1;
        @(posedge sysclk);
        #1;
        start_v[vecs[v].inst] = 1'b0;
        check_frame(vecs[v].inst, vecs[v].exp, vecs[v].nb, vecs[v].cpb, $sformatf("vec%0d", v));
        check_idle(vecs[v].inst, 3, $sformatf("vec%0d", v));
    endtask

    initial begin
        vecs[0] = '{0, 32'h5A,  16'(10'b0_01011010_1),            10, 50};
        vecs[1] = '{0, 32'h01,  16'(10'b0_10000000_1),            10, 50};
        vecs[2] = '{1, 32'hC3,  16'(12'b0_11000011_0_11),         12, 4};
        vecs[3] = '{1, 32'h80,  16'(12'b0_10000000_1_11),         12, 4};
        vecs[4] = '{2, 32'hFFF, 16'(15'b0_111111111111_1_1),      15, 3};
        vecs[5] = '{2, 32'h001, 16'(15'b0_100000000000_0_1),      15, 3};
        vecs[6] = '{3, 32'hA,   16'(6'b0_0101_1),                 6,  1};

        reset_n = 1'b0;
        start_v = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) @(posedge sysclk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset u%0d {cereal,ready,busy,done}", i),
                int'({cer_v[i], rdy_v[i], busy_v[i], done_v[i]}), 12);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) check_idle(i, 2, $sformatf("post-reset u%0d", i));

        // Directed frames from the table.
        for (int v = 0; v < 7; v++) run_vec(v);

        // Back-to-back: start held, data changed mid-frame 1.
        @(posedge sysclk);
        #1;
        d0 = 8'h5A;
        start_v[0] = 1'b1;
        fork
            begin
                repeat (100) @(posedge sysclk);
                #1;
                d0 = 8'hA5;
            end
        join_none
        @(posedge sysclk);
        #1;
        check_frame(0, vecs[0].exp, 10, 50, "b2b frame1");
        @(posedge sysclk);
        #1;
        start_v[0] = 1'b0;
        check_frame(0, 16'(10'b0_10100101_1), 10, 50, "b2b frame2");
        check_idle(0, 5, "b2b tail");

        // Start pulse and data change while busy are ignored.
        @(posedge sysclk);
        #1;
        d1 = 8'hC3;
        start_v[1] = 1'b1;
        @(posedge sysclk);
        #1;
        start_v[1] = 1'b0;
        fork
            begin
                repeat (10) @(posedge sysclk);
                #1;
                start_v[1] = 1'b1;
                d1 = 8'hFF;
                @(posedge sysclk);
                #1;
                start_v[1] = 1'b0;
            end
        join_none
        check_frame(1, vecs[2].exp, 12, 4, "interfere");
        check_idle(1, 20, "interfere tail");

        // Reset in the middle of data bit 3.
        @(posedge sysclk);
        #1;
        d0 = 8'h00;
        start_v[0] = 1'b1;
        @(posedge sysclk);
        #1;
        start_v[0] = 1'b0;
        repeat (220) @(posedge sysclk);
        #1;
        chk("pre-reset {cereal,busy}", int'({cer_v[0], busy_v[0]}), 1);
        reset_n = 1'b0;
        #1;
        chk("mid-frame reset {cereal,ready,busy,done}",
            int'({cer_v[0], rdy_v[0], busy_v[0], done_v[0]}), 12);
        #2;
        reset_n = 1'b1;
        check_idle(0, 3, "after reset");
        run_vec(0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
